// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bit-level sequencer: command codes, FSM states
// and the SCL/SDA waveform tables for each bus primitive.
package i2c_pkg;

  typedef enum logic [1:0] {
    CMD_START = 2'b00,
    CMD_STOP  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_READ  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH_A = 3'd1,
    PH_B = 3'd2,
    PH_C = 3'd3,
    PH_D = 3'd4
  } state_e;

  // Waveform tables: {scl,sda} pairs packed A (MSBs) through D (LSBs).
  localparam logic [7:0] START_SEQ    = 8'b11_11_10_00;
  localparam logic [7:0] STOP_SEQ     = 8'b00_10_10_11;
  localparam logic [3:0] DATA_SCL_SEQ = 4'b0110;

  function automatic logic [1:0] phase_idx(input state_e st);
    logic [1:0] idx;
    idx = 2'd0;
    case (st)
      PH_A:    idx = 2'd3;
      PH_B:    idx = 2'd2;
      PH_C:    idx = 2'd1;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [1:0] phase_bits(input state_e st, input cmd_e c, input logic d);
    logic [1:0] idx;
    logic [1:0] bits;
    idx  = phase_idx(st);
    bits = 2'b11;
    case (c)
      CMD_START: bits = START_SEQ[{idx, 1'b0} +: 2];
      CMD_STOP:  bits = STOP_SEQ[{idx, 1'b0} +: 2];
      CMD_WRITE: bits = {DATA_SCL_SEQ[idx], d};
      default:   bits = {DATA_SCL_SEQ[idx], 1'b1};
    endcase
    return bits;
  endfunction

  function automatic state_e next_phase(input state_e st);
    state_e nxt;
    nxt = IDLE;
    case (st)
      PH_A:    nxt = PH_B;
      PH_B:    nxt = PH_C;
      PH_C:    nxt = PH_D;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/dff_default_high.sv
// Enable-gated register that resets to all ones, used for open-drain drive
// lines whose released (idle) level is high.
module dff_default_high #(
  parameter int DATA_WITDT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iden,
  input  logic [DATA_WITDT-1:0] i_data,
  output logic [DATA_WITDT-1:0] o_data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data <= '1;
    end else if (iden) begin
      o_data <= i_data;
    end
  end

endmodule

// File: rtl/i2c_bit_ctrl.sv
// I2C bit sequencer: expands START/STOP/WRITE/READ into four timed SCL/SDA
// phases, honouring slave clock stretching and sampling SDA for reads.
module i2c_bit_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic       cmd_din,
  output logic       rsp_valid,
  output logic       rsp_dout,
  output logic       busy,
  output logic       scl_o,
  output logic       sda_o,
  input  logic       scl_i,
  input  logic       sda_i
);

  localparam int               CNT_W   = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cmd_e             cmd_q, cmd_d;
  logic             din_q, din_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_dout_q, rsp_dout_d;
  logic [1:0]       scl_sync_q, sda_sync_q;
  logic             bus_en;
  logic [1:0]       bus_d, bus_q;

  // Pad readbacks are asynchronous; synchronizers idle high like the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_q       <= CMD_START;
      din_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dout_q  <= rsp_dout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    din_d       = din_q;
    rsp_valid_d = 1'b0;
    rsp_dout_d  = rsp_dout_q;
    bus_en      = 1'b0;
    bus_d       = bus_q;

    if (state_q == IDLE) begin
      if (cmd_valid) begin
        cmd_d   = cmd_e'(cmd);
        din_d   = cmd_din;
        state_d = PH_A;
        cnt_d   = CNT_MAX;
        bus_en  = 1'b1;
        bus_d   = phase_bits(PH_A, cmd_e'(cmd), cmd_din);
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else if (state_q == PH_B && !scl_sync_q[1]) begin
      // Slave is stretching SCL: park at the end of PH_B until it lets go.
      cnt_d = '0;
    end else begin
      cnt_d   = CNT_MAX;
      state_d = next_phase(state_q);
      if (state_q == PH_C) begin
        rsp_dout_d = sda_sync_q[1];
      end
      if (state_q == PH_D) begin
        rsp_valid_d = 1'b1;
      end else begin
        bus_en = 1'b1;
        bus_d  = phase_bits(next_phase(state_q), cmd_q, din_q);
      end
    end
  end

  dff_default_high #(
    .DATA_WITDT(2)
  ) u_bus_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .iden  (bus_en),
    .i_data(bus_d),
    .o_data(bus_q)
  );

  assign {scl_o, sda_o} = bus_q;
  assign cmd_ready      = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_dout       = rsp_dout_q;

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Directed bench for i2c_bit_ctrl: expected per-cycle bus values are queued when
// a command is issued and popped one per cycle as the DUT runs.
module tb_i2c_bit_ctrl;

  localparam int CLK_DIV    = 4;
  localparam int CMD_CYCLES = 4 * CLK_DIV + 1;

  typedef struct {
    string      tag;
    logic [3:0] bus;   // {scl_o, sda_o, rsp_valid, busy}
    logic       chk;
    logic       dout;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic       cmd_din = 1'b0;
  logic       cmd_ready, rsp_valid, rsp_dout, busy, scl_o, sda_o;
  logic       sclIn, sdaIn;
  logic       stretch = 1'b0;
  logic       slavePull = 1'b0;

  int   total = 0;
  int   bad = 0;
  exp_t expQ[$];

  assign sclIn = stretch ? 1'b0 : scl_o;
  assign sdaIn = sda_o & ~slavePull;

  always #5 clk = ~clk;

  i2c_bit_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd      (cmd),
    .cmd_din  (cmd_din),
    .rsp_valid(rsp_valid),
    .rsp_dout (rsp_dout),
    .busy     (busy),
    .scl_o    (scl_o),
    .sda_o    (sda_o),
    .scl_i    (sclIn),
    .sda_i    (sdaIn)
  );

  // Reference waveform {scl, sda} for phase 0..3 (A..D) of each primitive.
  function automatic logic [1:0] busModel(input logic [1:0] c, input logic d, input int ph);
    logic [1:0] r;
    r = 2'b11;
    case (c)
      2'b00: r = (ph <= 1) ? 2'b11 : (ph == 2) ? 2'b10 : 2'b00;
      2'b01: r = (ph == 0) ? 2'b00 : (ph == 3) ? 2'b11 : 2'b10;
      2'b10: r = {(ph == 1 || ph == 2), d};
      default: r = {(ph == 1 || ph == 2), 1'b1};
    endcase
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [1:0] c, input logic d,
                               input int extra, input int upto, input logic dout);
    cmd_valid = 1'b1;
    cmd       = c;
    cmd_din   = d;
    for (int k = 1; k <= CMD_CYCLES + extra && k <= upto; k++) begin
      exp_t e;
      int   ph;
      logic last;
      if (k <= CLK_DIV) ph = 0;
      else if (k <= 2 * CLK_DIV + extra) ph = 1;
      else if (k <= 3 * CLK_DIV + extra) ph = 2;
      else ph = 3;
      last   = (k == CMD_CYCLES + extra);
      e.tag  = tag;
      e.bus  = {busModel(c, d, ph), last, ~last};
      e.chk  = last;
      e.dout = dout;
      expQ.push_back(e);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL scoreboard: observed=empty expected=entry");
    end else begin
      e = expQ.pop_front();
      total++;
      assert ({scl_o, sda_o, rsp_valid, busy} === e.bus) else begin
        bad++;
        $error("[TB] FAIL %s bus @%0t: observed=%b expected=%b", e.tag, $time,
               {scl_o, sda_o, rsp_valid, busy}, e.bus);
      end
      if (e.chk) checkBit({e.tag, " rsp_dout"}, rsp_dout, e.dout);
    end
  endtask

  task automatic checkCycles(input int n, input int pullFrom, input int pullTo, input int releaseAt);
    for (int i = 1; i <= n; i++) begin
      if (i == pullFrom) slavePull = 1'b1;
      if (i == pullTo + 1) slavePull = 1'b0;
      if (i == releaseAt) stretch = 1'b0;
      checkOutput();
      if (i < n) step();
    end
  endtask

  initial begin
    #12;
    checkBit("reset scl_o", scl_o, 1'b1);
    checkBit("reset sda_o", sda_o, 1'b1);
    checkBit("reset cmd_ready", cmd_ready, 1'b1);
    checkBit("reset rsp_valid", rsp_valid, 1'b0);
    checkBit("reset busy", busy, 1'b0);
    checkBit("reset rsp_dout", rsp_dout, 1'b0);
    rst_n = 1'b1;
    step();

    $display("[TB] START");
    applyStimulus("start", 2'b00, 1'b0, 0, 99, 1'b0);
    step();
    cmd_valid = 1'b0;
    checkCycles(CMD_CYCLES, 0, 0, 0);
    checkBit("start ready", cmd_ready, 1'b1);
    step();

    $display("[TB] WRITE 0 then WRITE 1 back-to-back");
    applyStimulus("wr0", 2'b10, 1'b0, 0, 99, 1'b0);
    step();
    applyStimulus("wr1", 2'b10, 1'b1, 0, 99, 1'b1);
    checkCycles(CMD_CYCLES, 0, 0, 0);
    checkBit("wr0 ready", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    checkCycles(CMD_CYCLES, 0, 0, 0);
    step();

    $display("[TB] READ with slave low, then released");
    applyStimulus("rd_low", 2'b11, 1'b0, 0, 99, 1'b0);
    step();
    cmd_valid = 1'b0;
    checkCycles(CMD_CYCLES, 9, 12, 0);
    step();
    applyStimulus("rd_high", 2'b11, 1'b0, 0, 99, 1'b1);
    step();
    cmd_valid = 1'b0;
    checkCycles(CMD_CYCLES, 0, 0, 0);
    step();

    $display("[TB] WRITE with clock stretch");
    stretch = 1'b1;
    applyStimulus("stretch", 2'b10, 1'b1, 15, 99, 1'b1);
    step();
    cmd_valid = 1'b0;
    checkCycles(CMD_CYCLES + 15, 0, 0, 21);
    step();

    $display("[TB] reset during READ");
    applyStimulus("rd_rst", 2'b11, 1'b1, 0, 9, 1'b0);
    step();
    cmd_valid = 1'b0;
    checkCycles(9, 0, 0, 0);
    step();
    rst_n = 1'b0;
    #1;
    checkBit("rst scl_o", scl_o, 1'b1);
    checkBit("rst sda_o", sda_o, 1'b1);
    checkBit("rst busy", busy, 1'b0);
    checkBit("rst cmd_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      checkBit("rst rsp_valid", rsp_valid, 1'b0);
    end
    rst_n = 1'b1;
    step();
    checkBit("post-rst ready", cmd_ready, 1'b1);
    checkBit("post-rst rsp_valid", rsp_valid, 1'b0);
    applyStimulus("stop", 2'b01, 1'b0, 0, 99, 1'b0);
    step();
    cmd_valid = 1'b0;
    checkCycles(CMD_CYCLES, 0, 0, 0);

    total++;
    assert (expQ.size() == 0) else begin
      bad++;
      $error("[TB] FAIL scoreboard drain: observed=%0d expected=0", expQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
